// File: rtl/overflow_range_buffer_pkg.sv
// Shared types for the overflow range buffer: the stored range entry and default sizing.
package overflow_range_buffer_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int ENTRY_AW      = 32;

    // Entries are stored at ENTRY_AW bits, so the top-level AW is expected to match it.
    typedef struct packed {
        logic                valid;
        logic [ENTRY_AW-1:0] first;
        logic [ENTRY_AW-1:0] last;
    } range_entry_t;

endpackage

// File: rtl/overflow_range_buffer_range_match.sv
// Single-entry comparator: checks one stored range against the lookup and run-base addresses.
module range_match
    import overflow_range_buffer_pkg::*;
(
    input  range_entry_t        entry,
    input  logic [ENTRY_AW-1:0] find_addr,
    input  logic [ENTRY_AW-1:0] base_addr,
    output logic                in_range,
    output logic                is_first,
    output logic                overflow
);

    // An invalid entry never matches, even though its zeroed bounds would cover address 0.
    assign in_range = entry.valid && (find_addr >= entry.first) && (find_addr <= entry.last);
    assign is_first = entry.valid && (find_addr == entry.first);
    assign overflow = entry.valid && (base_addr == entry.first) && (find_addr > entry.last);

endmodule

// File: rtl/overflow_range_buffer.sv
// Circular buffer of address ranges with merge-on-same-first, combinational lookup and debug read.
module overflow_range_buffer
    import overflow_range_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = ENTRY_AW
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     en_write_i,
    input  logic [AW-1:0]            addr_first_i,
    input  logic [AW-1:0]            addr_last_i,
    input  logic [AW-1:0]            find_addr_i,
    input  logic [AW-1:0]            base_addr_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic                     addr_in_range_o,
    output logic                     addr_is_first_o,
    output logic                     read_overflow_o,
    output logic [AW-1:0]            rd_first_o,
    output logic [AW-1:0]            rd_last_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     wrapped_o,
    output logic                     reject_o
);

    localparam int IW = $clog2(DEPTH);

    range_entry_t     entries [DEPTH];
    logic [IW-1:0]    wr_ptr;
    logic [IW:0]      count;
    logic             wrapped;
    logic             reject;
    logic [AW-1:0]    rd_first;
    logic [AW-1:0]    rd_last;

    logic [DEPTH-1:0] hit_range;
    logic [DEPTH-1:0] hit_first;
    logic [DEPTH-1:0] hit_over;
    logic [DEPTH-1:0] merge_hit;
    logic             bad_range;
    logic             full;

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        range_match u_match (
            .entry     (entries[g]),
            .find_addr (find_addr_i),
            .base_addr (base_addr_i),
            .in_range  (hit_range[g]),
            .is_first  (hit_first[g]),
            .overflow  (hit_over[g])
        );
    end

    assign addr_in_range_o = |hit_range;
    assign addr_is_first_o = |hit_first;
    assign read_overflow_o = |hit_over;

    // A new range sharing its first address with a live entry extends that entry instead of taking a slot.
    always_comb begin
        merge_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            merge_hit[i] = entries[i].valid && (entries[i].first == addr_first_i);
        end
    end

    assign bad_range = addr_first_i > addr_last_i;
    assign full      = count == (IW+1)'(DEPTH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            wr_ptr   <= '0;
            count    <= '0;
            wrapped  <= 1'b0;
            reject   <= 1'b0;
            rd_first <= '0;
            rd_last  <= '0;
        end else begin
            reject   <= 1'b0;
            rd_first <= entries[rd_idx_i].valid ? entries[rd_idx_i].first : '0;
            rd_last  <= entries[rd_idx_i].valid ? entries[rd_idx_i].last  : '0;

            if (clear_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    entries[i] <= '0;
                end
                wr_ptr  <= '0;
                count   <= '0;
                wrapped <= 1'b0;
            end else if (en_write_i) begin
                if (bad_range) begin
                    reject <= 1'b1;
                end else if (|merge_hit) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (merge_hit[i] && (addr_last_i > entries[i].last)) begin
                            entries[i].last <= addr_last_i;
                        end
                    end
                end else begin
                    // Slots fill in order, so once full the slot at wr_ptr is always the oldest.
                    entries[wr_ptr] <= '{valid: 1'b1, first: addr_first_i, last: addr_last_i};
                    wr_ptr          <= wr_ptr + IW'(1);
                    if (full) begin
                        wrapped <= 1'b1;
                    end else begin
                        count <= count + (IW+1)'(1);
                    end
                end
            end
        end
    end

    assign rd_first_o = rd_first;
    assign rd_last_o  = rd_last;
    assign count_o    = count;
    assign full_o     = full;
    assign wrapped_o  = wrapped;
    assign reject_o   = reject;

endmodule

// File: tb/tb_overflow_range_buffer.sv
// Self-checking bench for overflow_range_buffer: directed scenarios then random traffic against a queue model.
module tb_overflow_range_buffer;

    localparam int DEPTH = 8;
    localparam int AW    = 32;
    localparam int IW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          clear_i = 1'b0;
    logic          en_write_i = 1'b0;
    logic [AW-1:0] addr_first_i = '0;
    logic [AW-1:0] addr_last_i = '0;
    logic [AW-1:0] find_addr_i = '0;
    logic [AW-1:0] base_addr_i = '0;
    logic [IW-1:0] rd_idx_i = '0;
    logic          addr_in_range_o;
    logic          addr_is_first_o;
    logic          read_overflow_o;
    logic [AW-1:0] rd_first_o;
    logic [AW-1:0] rd_last_o;
    logic [IW:0]   count_o;
    logic          full_o;
    logic          wrapped_o;
    logic          reject_o;

    always #5 clk = ~clk;

    overflow_range_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .clear_i         (clear_i),
        .en_write_i      (en_write_i),
        .addr_first_i    (addr_first_i),
        .addr_last_i     (addr_last_i),
        .find_addr_i     (find_addr_i),
        .base_addr_i     (base_addr_i),
        .rd_idx_i        (rd_idx_i),
        .addr_in_range_o (addr_in_range_o),
        .addr_is_first_o (addr_is_first_o),
        .read_overflow_o (read_overflow_o),
        .rd_first_o      (rd_first_o),
        .rd_last_o       (rd_last_o),
        .count_o         (count_o),
        .full_o          (full_o),
        .wrapped_o       (wrapped_o),
        .reject_o        (reject_o)
    );

    // Model: live ranges in insertion order; an insertion number n lives in slot n % DEPTH.
    typedef struct {
        logic [AW-1:0] first;
        logic [AW-1:0] last;
        int            seq;
    } rng_t;

    rng_t          q[$];
    int            n_ins = 0;
    logic          exp_reject = 1'b0;
    logic [AW-1:0] exp_rd_first = '0;
    logic [AW-1:0] exp_rd_last = '0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_in_range(input logic [AW-1:0] a);
        foreach (q[k]) if (a >= q[k].first && a <= q[k].last) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_is_first(input logic [AW-1:0] a);
        foreach (q[k]) if (a == q[k].first) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_overflow(input logic [AW-1:0] b, input logic [AW-1:0] a);
        foreach (q[k]) if (b == q[k].first && a > q[k].last) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        exp_reject   = 1'b0;
        exp_rd_first = '0;
        exp_rd_last  = '0;
        if (rst_i) begin
            q.delete();
            n_ins = 0;
            return;
        end
        foreach (q[k]) begin
            if (q[k].seq % DEPTH == int'(rd_idx_i)) begin
                exp_rd_first = q[k].first;
                exp_rd_last  = q[k].last;
            end
        end
        if (clear_i) begin
            q.delete();
            n_ins = 0;
        end else if (en_write_i) begin
            if (addr_first_i > addr_last_i) begin
                exp_reject = 1'b1;
            end else begin
                bit merged = 1'b0;
                foreach (q[k]) begin
                    if (q[k].first == addr_first_i) begin
                        merged = 1'b1;
                        if (addr_last_i > q[k].last) q[k].last = addr_last_i;
                    end
                end
                if (!merged) begin
                    q.push_back('{addr_first_i, addr_last_i, n_ins});
                    n_ins++;
                    if (q.size() > DEPTH) void'(q.pop_front());
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".count"},   AW'(count_o),   AW'(q.size()));
        check({tag, ".full"},    AW'(full_o),    AW'(q.size() == DEPTH));
        check({tag, ".wrapped"}, AW'(wrapped_o), AW'(n_ins > DEPTH));
        check({tag, ".reject"},  AW'(reject_o),  AW'(exp_reject));
        check({tag, ".rdfirst"}, rd_first_o,     exp_rd_first);
        check({tag, ".rdlast"},  rd_last_o,      exp_rd_last);
        check({tag, ".inrange"}, AW'(addr_in_range_o), AW'(model_in_range(find_addr_i)));
        check({tag, ".isfirst"}, AW'(addr_is_first_o), AW'(model_is_first(find_addr_i)));
        check({tag, ".ovf"},     AW'(read_overflow_o), AW'(model_overflow(base_addr_i, find_addr_i)));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        rst_i      = 1'b0;
        clear_i    = 1'b0;
        en_write_i = 1'b0;
        checkOutput(tag);
    endtask

    task automatic lookup(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] find);
        base_addr_i = base;
        find_addr_i = find;
        #1;
        check({tag, ".inrange"}, AW'(addr_in_range_o), AW'(model_in_range(find)));
        check({tag, ".isfirst"}, AW'(addr_is_first_o), AW'(model_is_first(find)));
        check({tag, ".ovf"},     AW'(read_overflow_o), AW'(model_overflow(base, find)));
    endtask

    task automatic applyStimulus(input string tag, input logic [AW-1:0] f, input logic [AW-1:0] l);
        addr_first_i = f;
        addr_last_i  = l;
        en_write_i   = 1'b1;
        tick(tag);
    endtask

    function automatic logic [AW-1:0] rand_first();
        if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFF0;
        return 32'h100 + 32'($urandom_range(0, 11)) * 32'h10;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        tick("reset");
        check("reset.count_const", AW'(count_o), '0);
        lookup("reset.lk", 32'h0, 32'h0);

        // A single range and its lookups.
        applyStimulus("w1000", 32'h1000, 32'h1007);
        lookup("lk1004", 32'h0, 32'h1004);
        check("lk1004.in_const", AW'(addr_in_range_o), 32'd1);
        check("lk1004.first_const", AW'(addr_is_first_o), 32'd0);
        lookup("lk1000", 32'h0, 32'h1000);
        check("lk1000.first_const", AW'(addr_is_first_o), 32'd1);
        lookup("lk1008", 32'h0, 32'h1008);
        check("lk1008.in_const", AW'(addr_in_range_o), 32'd0);
        lookup("ovf1009", 32'h1000, 32'h1009);
        check("ovf1009.const", AW'(read_overflow_o), 32'd1);
        lookup("ovf1007", 32'h1000, 32'h1007);
        check("ovf1007.const", AW'(read_overflow_o), 32'd0);

        // Same-first writes merge into one entry.
        clear_i = 1'b1;
        tick("clr1");
        applyStimulus("w2000a", 32'h2000, 32'h2003);
        applyStimulus("w2000b", 32'h2000, 32'h200F);
        check("merge.count_const", AW'(count_o), 32'd1);
        lookup("lk200c", 32'h0, 32'h200C);
        check("lk200c.in_const", AW'(addr_in_range_o), 32'd1);

        // Inverted range is rejected; clear beats a simultaneous write.
        applyStimulus("bad", 32'h30, 32'h20);
        check("bad.reject_const", AW'(reject_o), 32'd1);
        check("bad.count_const", AW'(count_o), 32'd1);
        tick("bad_after");
        check("bad.pulse_const", AW'(reject_o), 32'd0);
        clear_i = 1'b1;
        applyStimulus("clr_wr", 32'h5000, 32'h5003);
        check("clr_wr.count_const", AW'(count_o), 32'd0);
        lookup("clr_wr.lk", 32'h0, 32'h5000);

        // Overfill by one: the oldest slot is recycled.
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus("fill", 32'h4000 + 32'(i) * 32'h100, 32'h400F + 32'(i) * 32'h100);
        end
        rd_idx_i = '0;
        tick("rd0");
        check("wrap.count_const", AW'(count_o), 32'd8);
        check("wrap.full_const", AW'(full_o), 32'd1);
        check("wrap.wrapped_const", AW'(wrapped_o), 32'd1);
        check("wrap.rd0_const", rd_first_o, 32'h4800);
        lookup("wrap.lk4000", 32'h0, 32'h4000);
        check("wrap.lk4000_const", AW'(addr_in_range_o), 32'd0);

        // Reset mid-sequence with three entries.
        clear_i = 1'b1;
        tick("clr2");
        applyStimulus("r1", 32'h600, 32'h60F);
        applyStimulus("r2", 32'h700, 32'h70F);
        applyStimulus("r3", 32'h800, 32'h80F);
        rd_idx_i    = IW'(1);
        find_addr_i = 32'h704;
        rst_i       = 1'b1;
        tick("rst_mid");
        check("rst_mid.count_const", AW'(count_o), 32'd0);
        check("rst_mid.in_const", AW'(addr_in_range_o), 32'd0);
        tick("rst_mid_rd");
        check("rst_mid.rd_const", rd_last_o, 32'd0);

        // Random traffic.
        for (int it = 0; it < 400; it++) begin
            int op;
            logic [AW-1:0] f;
            op = int'($urandom_range(0, 99));
            f  = rand_first();
            rd_idx_i = IW'($urandom_range(0, DEPTH - 1));
            addr_first_i = f;
            if (op < 8) begin
                addr_last_i = f - 32'(1 + $urandom_range(0, 3));
            end else if (f == 32'hFFFF_FFF0) begin
                addr_last_i = f + 32'($urandom_range(0, 15));
            end else begin
                addr_last_i = f + 32'($urandom_range(0, 40));
            end
            en_write_i = (op < 80);
            clear_i    = (op >= 90 && op < 95);
            rst_i      = (op >= 97);
            tick("rnd");
            lookup("rnd.lk", rand_first(),
                   ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                               : 32'h100 + 32'($urandom_range(0, 220)));
            lookup("rnd.lk2", rand_first(), rand_first() + 32'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/overflow_range_buffer.md
OVERFLOW_RANGE_BUFFER -- requirements
Module: overflow_range_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the number of range entries (power of two, 2..32).
REQ-002 SHALL have parameter AW, default 32, the address width.
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk_i  in  1  clock, all state on rising edge.
REQ-004 SHALL have rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have clear_i  in  1  synchronous flush of all entries.
REQ-006 SHALL have en_write_i  in  1  write strobe, one range per cycle.
REQ-007 SHALL have addr_first_i  in  AW  first byte address of the written range.
REQ-008 SHALL have addr_last_i  in  AW  last byte address of the written range, inclusive.
REQ-009 SHALL have find_addr_i  in  AW  lookup address.
REQ-010 SHALL have base_addr_i  in  AW  base address of the current sequential-read run.
REQ-011 SHALL have rd_idx_i  in  $clog2(DEPTH)  debug read index.
REQ-012 SHALL have addr_in_range_o  out  1  find_addr_i lies in a valid entry (first<=a<=last).
REQ-013 SHALL have addr_is_first_o  out  1  find_addr_i equals first of a valid entry.
REQ-014 SHALL have read_overflow_o  out  1  base_addr_i equals first of a valid entry AND find_addr_i > that entry's last.
REQ-015 SHALL have rd_first_o  out  AW  first of entry rd_idx_i, registered.
REQ-016 SHALL have rd_last_o  out  AW  last of entry rd_idx_i, registered.
REQ-017 SHALL have count_o  out  $clog2(DEPTH)+1  number of valid entries.
REQ-018 SHALL have full_o  out  1  count_o==DEPTH.
REQ-019 SHALL have wrapped_o  out  1  sticky: an entry was overwritten since the last reset/clear.
REQ-020 SHALL have reject_o  out  1  one-cycle pulse: a write was rejected.

Function
REQ-021 Storage SHALL be DEPTH entries {valid, first, last} plus write pointer wr_ptr.
REQ-022 Lookup outputs (012-014) SHALL be combinational from the current registered entries; a same-cycle write is not visible until the next cycle.
REQ-023 A write with addr_first_i > addr_last_i (unsigned) SHALL be rejected: no state change; reject_o pulses the next cycle.
REQ-024 A write whose first equals a valid entry's first SHALL merge: that entry's last becomes max(stored last, addr_last_i); wr_ptr and count unchanged.
REQ-025 Otherwise the write SHALL store at wr_ptr, set valid, and advance wr_ptr modulo DEPTH (DEPTH-1 -> 0).
REQ-026 If not full, a new write SHALL increment count_o.
REQ-027 If full, a new write SHALL overwrite the oldest entry (at wr_ptr), hold count_o at DEPTH, and set wrapped_o.
REQ-028 Multiple matching entries on lookup SHALL be OR-reduced; no priority is needed.
REQ-029 rd_first_o/rd_last_o SHALL present entry rd_idx_i one cycle after rd_idx_i is applied; an invalid entry reads as 0.
REQ-030 clear_i SHALL invalidate all entries and zero wr_ptr, count_o and wrapped_o next cycle; clear_i takes precedence over a same-cycle en_write_i, which is dropped without reject.
REQ-031 Address comparisons SHALL be unsigned AW-bit; no wrap across address 0.

Reset
REQ-032 On rst_i high at a clock edge, all entries SHALL become invalid with first/last=0, and wr_ptr, count_o, wrapped_o, reject_o, rd_first_o and rd_last_o SHALL become 0; rst_i dominates clear_i and en_write_i.
REQ-033 After reset, all lookup outputs SHALL be 0 until the first accepted write.

Structure
REQ-034 The entry struct typedef (range_entry_t: valid, first, last) and the DEPTH default SHALL live in the shared INSA package, alongside ariane_pkg usage.
REQ-035 One sub-module, range_match (a single-entry comparator producing in_range, is_first and overflow), SHALL be instantiated DEPTH times; all else is flat.

Verification
REQ-036 Write [0x1000,0x1007]; the next cycle find 0x1004 -> in_range=1, is_first=0; find 0x1000 -> is_first=1; find 0x1008 -> in_range=0.
REQ-037 base=0x1000, find=0x1009 after the REQ-036 write -> read_overflow_o=1; find=0x1007 -> read_overflow_o=0.
REQ-038 Write DEPTH+1 distinct ranges -> count_o=8, full_o=1, wrapped_o=1, entry 0 holds the ninth range, and the first range is no longer found.
REQ-039 Write [0x2000,0x2003] then [0x2000,0x200F] -> count_o=1; find 0x200C -> in_range=1.
REQ-040 Write [0x30,0x20] -> reject_o pulses once and count_o is unchanged; clear_i together with a write -> count_o=0 and no entry is stored.
REQ-041 Assert rst_i in mid-sequence with 3 entries -> the next cycle count_o=0 and all outputs are 0.
